exponent_normalize_update: RTL and testbench
============================================

Name: exponent_normalize_update

Overview:
- Parametrised, pipelined successor to the add/sub exponent-update stage.
- Takes the raw mantissa sum, its carry-out and the pre-alignment exponent. Produces a normalised mantissa and an updated exponent.
- Normalisation covers a right shift on carry and a left shift by leading-zero count. Overflow, underflow-to-denormal and zero results are flagged.
- Sits between the mantissa adder and the rounding stage. Uses a valid/ready handshake so downstream stalls propagate back.

Parameters:
- ExponentSize, 8, width of the biased exponent.
- MantissaSize, 24, mantissa width including the hidden bit (MSB).
- LzcWidth, $clog2(MantissaSize+1), derived localparam, shift-count width.

Ports:
- Clk  in  1  clock, all registers on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- InValid  in  1  input beat valid.
- InReady  out  1  block can accept an input beat this cycle.
- InExponent  in  ExponentSize  exponent before update.
- InMantissa  in  MantissaSize  mantissa sum, excluding carry.
- InCarry  in  1  carry-out of the mantissa adder.
- InSticky  in  1  sticky bit from alignment.
- InSign  in  1  result sign, passed through.
- OutValid  out  1  output beat valid.
- OutReady  in  1  downstream accepts the beat.
- OutExponent  out  ExponentSize  updated exponent.
- OutMantissa  out  MantissaSize  normalised mantissa.
- OutSticky  out  1  updated sticky.
- OutSign  out  1  sign.
- Overflow  out  1  exponent saturated to all-ones.
- Underflow  out  1  result became denormal.
- Zero  out  1  result is exact zero.

Behaviour:
- Reset: all stage-valid registers are 0, so OutValid=0 and InReady=1. All data outputs and flags are 0. Reset asserted mid-operation discards in-flight beats immediately.
- Pipeline has two register stages, S1 and S2. Latency is 2 cycles from input handshake to OutValid when there is no stall. Throughput is 1 beat per cycle.
- Handshake:
  - adv2 = !V2 | OutReady.
  - adv1 = !V1 | adv2.
  - InReady = adv1, a combinational function of state and OutReady.
  - A beat transfers when Valid & Ready are both high. Output data are held stable while OutValid & !OutReady.
  - No beat is lost or duplicated, and order is preserved.
- S1 registers the inputs plus the leading-zero count (lzc) of InMantissa. A priority encoder from the MSB gives lzc = MantissaSize when the mantissa is all zeros.
- S2 computes from the S1 registers, checking cases in priority order:
  1. Carry=1: mantissa = {1, M[MantissaSize-1:1]}, sticky = M[0] | sticky, exponent = E+1.
     - If E+1 equals all-ones: Overflow=1, OutExponent=all-ones, OutMantissa=0.
  2. Carry=0 and M=0: OutExponent=0, OutMantissa=0, Zero=1, sticky passed through.
  3. E=0, input already denormal: no shift, exponent 0.
  4. lzc < E: mantissa = M << lzc, exponent = E - lzc.
  5. lzc >= E, with E>0: mantissa = M << (E-1), exponent = 0, Underflow=1.
- Flags are mutually exclusive. Sign is passed through unchanged.
- Arithmetic:
  - Exponent math uses ExponentSize+1 bits internally before the saturate check.
  - Shift amounts are LzcWidth bits wide and are compared zero-extended against E.
- Simultaneous events: when an input is accepted on the same cycle S2 drains, both S1 and S2 update, and V1 and V2 remain 1.

Decomposition:
- Shared package fp_pkg: default ExponentSize and MantissaSize, an exponent all-ones constant, and a flags typedef {Overflow, Underflow, Zero}.
- One sub-module, leading_zero_counter, is parametrised by MantissaSize. It outputs lzc and an all-zero indication and is reused by the multiply normaliser.

Test Plan:
1. Carry path: E=0x7F, M=0x800001, Carry=1, Sticky=0 -> after 2 cycles: E=0x80, M=0xC00000, OutSticky=1, all flags 0.
2. Left normalise: E=0x80, M=0x00F000, Carry=0 -> E=0x78, M=0xF00000, flags 0.
3. Overflow: E=0xFE, M=0x800000, Carry=1 -> E=0xFF, M=0, Overflow=1.
4. Underflow and zero:
   - E=0x03, M=0x000100 -> E=0x00, M=0x000400, Underflow=1.
   - M=0, Carry=0 -> E=0, Zero=1.
5. Backpressure: stream 4 beats back-to-back while OutReady=0 for 3 cycles.
   - InReady drops once V1 and V2 are both 1.
   - Outputs stay stable while stalled.
   - All 4 beats emerge in order, with no gaps once OutReady=1.
6. Reset mid-stream: assert Rst with V1=V2=1 -> OutValid=0 and InReady=1 immediately. No stale beat appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the add/sub and multiply datapaths.
// Holds the default field widths, the saturated exponent value, and the
// exception flag bundle that the normalisers return.
package fp_pkg;

  localparam int DefaultExponentSize = 8;
  localparam int DefaultMantissaSize = 24;

  // Saturated exponent for the default format; parametrised blocks build
  // their own all-ones value at their configured width.
  localparam logic [DefaultExponentSize-1:0] DefaultExpAllOnes = '1;

  // Result exceptions. At most one of these is set for any given beat.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Leading-zero counter used by the add/sub and multiply normalisers.
// Ports:
//   mantissa_i  value to scan, MSB first
//   lzc_o       number of zero bits above the first set bit
//               (MantissaSize when the value is all zeros)
//   allZero_o   high when no bit of mantissa_i is set
module leading_zero_counter
  import fp_pkg::*;
#(
  parameter int MantissaSize = DefaultMantissaSize,
  localparam int LzcWidth = $clog2(MantissaSize + 1)
) (
  input  logic [MantissaSize-1:0] mantissa_i,
  output logic [LzcWidth-1:0]     lzc_o,
  output logic                    allZero_o
);

  // Scan from LSB upward so the highest set bit is the last one to write
  // the count; that makes the loop a priority encoder from the MSB.
  always_comb begin
    lzc_o     = LzcWidth'(MantissaSize);
    allZero_o = 1'b1;
    for (int i = 0; i < MantissaSize; i++) begin
      if (mantissa_i[i]) begin
        lzc_o     = LzcWidth'(MantissaSize - 1 - i);
        allZero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/exponent_normalize_update.sv
// Two-stage exponent update and mantissa normaliser between the mantissa
// adder and the rounding stage. Stage 1 registers the adder result and its
// leading-zero count; stage 2 picks the normalisation case and registers
// the outputs. Valid/ready handshake on both sides, one beat per cycle.
// Ports:
//   Clk, Rst                    clock, asynchronous active-high reset
//   InValid/InReady             input handshake
//   InExponent, InMantissa      pre-alignment exponent, raw mantissa sum
//   InCarry, InSticky, InSign   adder carry-out, alignment sticky, sign
//   OutValid/OutReady           output handshake
//   OutExponent, OutMantissa    updated exponent, normalised mantissa
//   OutSticky, OutSign          updated sticky, sign
//   Overflow, Underflow, Zero   mutually exclusive result flags
module exponent_normalize_update
  import fp_pkg::*;
#(
  parameter int ExponentSize = DefaultExponentSize,
  parameter int MantissaSize = DefaultMantissaSize,
  localparam int LzcWidth = $clog2(MantissaSize + 1)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [ExponentSize-1:0] InExponent,
  input  logic [MantissaSize-1:0] InMantissa,
  input  logic                    InCarry,
  input  logic                    InSticky,
  input  logic                    InSign,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [ExponentSize-1:0] OutExponent,
  output logic [MantissaSize-1:0] OutMantissa,
  output logic                    OutSticky,
  output logic                    OutSign,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Zero
);

  localparam logic [ExponentSize-1:0] ExpAllOnes = '1;
  localparam logic [ExponentSize:0]   ExpAllOnesWide = {1'b0, ExpAllOnes};

  // Stage 1 registers
  logic                    v1_q;
  logic [ExponentSize-1:0] exp1_q;
  logic [MantissaSize-1:0] mant1_q;
  logic                    carry1_q;
  logic                    sticky1_q;
  logic                    sign1_q;
  logic [LzcWidth-1:0]     lzc1_q;
  logic                    allZero1_q;

  // Stage 2 registers and their next-state values
  logic                    v2_q;
  logic [ExponentSize-1:0] exp2_q,    exp2_d;
  logic [MantissaSize-1:0] mant2_q,   mant2_d;
  logic                    sticky2_q, sticky2_d;
  logic                    sign2_q;
  flags_t                  flags2_q,  flags2_d;

  logic                    adv1, adv2;
  logic [LzcWidth-1:0]     lzcIn;
  logic                    allZeroIn;

  logic [ExponentSize:0]   incExp;
  logic [ExponentSize-1:0] lzcExt;
  logic [ExponentSize-1:0] denormShift;

  leading_zero_counter #(
    .MantissaSize(MantissaSize)
  ) lzcInst (
    .mantissa_i(InMantissa),
    .lzc_o     (lzcIn),
    .allZero_o (allZeroIn)
  );

  // A stage may load when it is empty or when the stage after it is
  // draining this cycle, so a downstream stall backs up one stage at a time.
  assign adv2    = !v2_q || OutReady;
  assign adv1    = !v1_q || adv2;
  assign InReady = adv1;

  // Stage 1 captures the beat together with its leading-zero count so the
  // priority encoder and the shifter sit in different cycles.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v1_q       <= 1'b0;
      exp1_q     <= '0;
      mant1_q    <= '0;
      carry1_q   <= 1'b0;
      sticky1_q  <= 1'b0;
      sign1_q    <= 1'b0;
      lzc1_q     <= '0;
      allZero1_q <= 1'b0;
    end else if (adv1) begin
      v1_q <= InValid;
      if (InValid) begin
        exp1_q     <= InExponent;
        mant1_q    <= InMantissa;
        carry1_q   <= InCarry;
        sticky1_q  <= InSticky;
        sign1_q    <= InSign;
        lzc1_q     <= lzcIn;
        allZero1_q <= allZeroIn;
      end
    end
  end

  assign incExp      = {1'b0, exp1_q} + (ExponentSize + 1)'(1);
  assign lzcExt      = ExponentSize'(lzc1_q);
  assign denormShift = exp1_q - ExponentSize'(1);

  // Normalisation cases in priority order. The increment is evaluated one
  // bit wider so an exponent of all-ones on entry still saturates rather
  // than wrapping to zero. The denormal case shifts only far enough to
  // land on exponent 0, leaving the remaining leading zeros in place.
  always_comb begin
    exp2_d    = exp1_q;
    mant2_d   = mant1_q;
    sticky2_d = sticky1_q;
    flags2_d  = '0;
    if (carry1_q) begin
      sticky2_d = mant1_q[0] | sticky1_q;
      if (incExp >= ExpAllOnesWide) begin
        exp2_d            = ExpAllOnes;
        mant2_d           = '0;
        flags2_d.overflow = 1'b1;
      end else begin
        exp2_d  = incExp[ExponentSize-1:0];
        mant2_d = {1'b1, mant1_q[MantissaSize-1:1]};
      end
    end else if (allZero1_q) begin
      exp2_d        = '0;
      mant2_d       = '0;
      flags2_d.zero = 1'b1;
    end else if (exp1_q == '0) begin
      exp2_d  = '0;
      mant2_d = mant1_q;
    end else if (lzcExt < exp1_q) begin
      exp2_d  = exp1_q - lzcExt;
      mant2_d = mant1_q << lzc1_q;
    end else begin
      exp2_d             = '0;
      mant2_d            = mant1_q << denormShift;
      flags2_d.underflow = 1'b1;
    end
  end

  // Stage 2 holds its beat while the consumer stalls and otherwise takes
  // whatever stage 1 holds, including a bubble.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v2_q      <= 1'b0;
      exp2_q    <= '0;
      mant2_q   <= '0;
      sticky2_q <= 1'b0;
      sign2_q   <= 1'b0;
      flags2_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        exp2_q    <= exp2_d;
        mant2_q   <= mant2_d;
        sticky2_q <= sticky2_d;
        sign2_q   <= sign1_q;
        flags2_q  <= flags2_d;
      end
    end
  end

  assign OutValid    = v2_q;
  assign OutExponent = exp2_q;
  assign OutMantissa = mant2_q;
  assign OutSticky   = sticky2_q;
  assign OutSign     = sign2_q;
  assign Overflow    = flags2_q.overflow;
  assign Underflow   = flags2_q.underflow;
  assign Zero        = flags2_q.zero;

endmodule

// File: tb/tb_exponent_normalize_update.sv
// Self-checking bench for exponent_normalize_update: a reference model
// fills a scoreboard when a beat is accepted, and a monitor compares the
// front entry against the outputs whenever OutValid is high.
module tb_exponent_normalize_update;

  localparam int ES = 8;
  localparam int MS = 24;

  typedef struct {
    logic [ES-1:0] exponent;
    logic [MS-1:0] mantissa;
    logic          sticky;
    logic          sign;
    logic [2:0]    flags;
  } expBeat_t;

  logic          Clk, Rst;
  logic          InValid, InReady;
  logic [ES-1:0] InExponent;
  logic [MS-1:0] InMantissa;
  logic          InCarry, InSticky, InSign;
  logic          OutValid, OutReady;
  logic [ES-1:0] OutExponent;
  logic [MS-1:0] OutMantissa;
  logic          OutSticky, OutSign;
  logic          Overflow, Underflow, Zero;

  int       errorCount = 0;
  int       checkCount = 0;
  expBeat_t scoreboard[$];
  bit       driverDone;

  exponent_normalize_update #(
    .ExponentSize(ES),
    .MantissaSize(MS)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .InValid    (InValid),
    .InReady    (InReady),
    .InExponent (InExponent),
    .InMantissa (InMantissa),
    .InCarry    (InCarry),
    .InSticky   (InSticky),
    .InSign     (InSign),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutExponent(OutExponent),
    .OutMantissa(OutMantissa),
    .OutSticky  (OutSticky),
    .OutSign    (OutSign),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Zero       (Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Reference normaliser written directly from the case list.
  function automatic expBeat_t modelBeat(input logic [ES-1:0] e,
                                         input logic [MS-1:0] m,
                                         input logic c, input logic st,
                                         input logic sg);
    expBeat_t r;
    int       lz;
    longint   wide;
    r.exponent = '0;
    r.mantissa = '0;
    r.sticky   = st;
    r.sign     = sg;
    r.flags    = 3'b000;
    lz = MS;
    for (int i = MS - 1; i >= 0; i--) begin
      if (m[i]) begin
        lz = MS - 1 - i;
        break;
      end
    end
    if (c) begin
      r.sticky = m[0] | st;
      if (int'(e) + 1 >= (1 << ES) - 1) begin
        r.exponent = '1;
        r.flags    = 3'b100;
      end else begin
        r.exponent = e + 8'd1;
        r.mantissa = {1'b1, m[MS-1:1]};
      end
    end else if (m == '0) begin
      r.flags = 3'b001;
    end else if (e == '0) begin
      r.mantissa = m;
    end else if (lz < int'(e)) begin
      wide       = longint'(m) << lz;
      r.mantissa = wide[MS-1:0];
      r.exponent = e - ES'(lz);
    end else begin
      wide       = longint'(m) << (int'(e) - 1);
      r.mantissa = wide[MS-1:0];
      r.flags    = 3'b010;
    end
    return r;
  endfunction

  task automatic compareBeat(input expBeat_t exp);
    checkOutput("exponent", 32'(OutExponent), 32'(exp.exponent));
    checkOutput("mantissa", 32'(OutMantissa), 32'(exp.mantissa));
    checkOutput("sticky",   32'(OutSticky),   32'(exp.sticky));
    checkOutput("sign",     32'(OutSign),     32'(exp.sign));
    checkOutput("flags", 32'({Overflow, Underflow, Zero}), 32'(exp.flags));
  endtask

  // Monitor samples on the falling edge, away from register updates. A
  // stalled beat is compared every cycle, which also proves it holds.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (OutValid) begin
        if (scoreboard.size() == 0) begin
          checkOutput("unexpectedBeat", 32'(OutValid), 32'd0);
        end else begin
          compareBeat(scoreboard[0]);
          if (OutReady) void'(scoreboard.pop_front());
        end
      end
      if (InValid && InReady)
        scoreboard.push_back(modelBeat(InExponent, InMantissa, InCarry,
                                       InSticky, InSign));
    end
  end

  // Presents one beat and holds it until the handshake completes.
  task automatic applyStimulus(input logic [ES-1:0] e, input logic [MS-1:0] m,
                               input logic c, input logic st, input logic sg);
    int  cycles;
    bit  accepted;
    InValid    = 1'b1;
    InExponent = e;
    InMantissa = m;
    InCarry    = c;
    InSticky   = st;
    InSign     = sg;
    cycles     = 0;
    accepted   = 1'b0;
    while (!accepted && cycles < 100) begin
      @(negedge Clk);
      accepted = InReady;
      cycles++;
    end
    if (!accepted) checkOutput("acceptTimeout", 32'(InReady), 32'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic drainWait();
    int cycles = 0;
    while (scoreboard.size() != 0 && cycles < 50) begin
      @(negedge Clk);
      cycles++;
    end
    checkOutput("drain", 32'(scoreboard.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst        = 1'b1;
    InValid    = 1'b0;
    InExponent = '0;
    InMantissa = '0;
    InCarry    = 1'b0;
    InSticky   = 1'b0;
    InSign     = 1'b0;
    OutReady   = 1'b1;
    driverDone = 1'b0;

    #3;
    checkOutput("rstOutValid", 32'(OutValid), 32'd0);
    checkOutput("rstInReady",  32'(InReady),  32'd1);
    checkOutput("rstExponent", 32'(OutExponent), 32'd0);
    checkOutput("rstMantissa", 32'(OutMantissa), 32'd0);
    checkOutput("rstFlags", 32'({Overflow, Underflow, Zero, OutSticky, OutSign}), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(8'h7F, 24'h800001, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h80, 24'h00F000, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hFE, 24'h800000, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h03, 24'h000100, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h55, 24'h000000, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h00, 24'h012345, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 24'h123456, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h18, 24'h000001, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h17, 24'h000001, 1'b0, 1'b0, 1'b0);
    drainWait();

    $display("[TB] backpressure");
    OutReady = 1'b0;
    fork
      begin
        applyStimulus(8'h40, 24'h400000, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h41, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h42, 24'h000F00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h02, 24'h00000F, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("stallInReady",  32'(InReady),  32'd0);
        checkOutput("stallOutValid", 32'(OutValid), 32'd1);
        OutReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge Clk);
          checkOutput("noGap", 32'(OutValid), 32'd1);
        end
      end
    join
    drainWait();

    $display("[TB] random traffic");
    driverDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          logic [MS-1:0] m;
          m = MS'($urandom) >> $urandom_range(0, MS);
          applyStimulus(ES'($urandom_range(0, 255)), m,
                        ($urandom_range(0, 3) == 0), 1'($urandom),
                        1'($urandom));
        end
        driverDone = 1'b1;
      end
      begin
        int guard = 0;
        while (!driverDone && guard < 2000) begin
          @(posedge Clk);
          #1;
          OutReady = 1'($urandom_range(0, 1));
          guard++;
        end
        OutReady = 1'b1;
      end
    join
    OutReady = 1'b1;
    drainWait();

    $display("[TB] reset mid-stream");
    OutReady = 1'b0;
    applyStimulus(8'h10, 24'h100000, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h11, 24'h200000, 1'b0, 1'b0, 1'b0);
    #1;
    Rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", 32'(OutValid), 32'd0);
    checkOutput("midRstInReady",  32'(InReady),  32'd1);
    checkOutput("midRstExponent", 32'(OutExponent), 32'd0);
    scoreboard.delete();
    @(posedge Clk);
    #1;
    Rst      = 1'b0;
    OutReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      checkOutput("noStaleBeat", 32'(OutValid), 32'd0);
    end
    applyStimulus(8'h90, 24'h000003, 1'b0, 1'b0, 1'b1);
    drainWait();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
